rng_word_buffer: RTL
====================

Name: rng_word_buffer

Overview:
- Downstream consumer of the free-running 128-bit maximal LFSR.
- Decimates the LFSR state so that successive output words share no shifted-in bits.
- Captures WIDTH-bit words into a small first-word-fall-through FIFO and hands them to a CPU/peripheral consumer over a valid/ready handshake.
- Counts consumer starvation events for software diagnostics.

Parameters:
- WIDTH, 32, output word width; legal range 1..128.
- DECIM, 32, cycles between samples; must be >= WIDTH so every sampled bit is freshly shifted in.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the saturating underrun counter.

Ports:
- clk, input, 1, single clock; rising edge.
- rst, input, 1, synchronous active-high reset.
- lfsr_state, input, 128, LFSR state; sampled bits are [WIDTH-1:0].
- out_data, output, WIDTH, FIFO head word.
- out_valid, output, 1, head word valid.
- out_ready, input, 1, consumer accepts the head word this cycle.
- fill, output, $clog2(DEPTH)+1, current number of FIFO entries.
- underrun_cnt, output, CNT_W, saturating count of starved cycles.
- drop, output, 1, one-cycle pulse when a sample is discarded because the FIFO is full.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - Decimation counter is 0; FIFO is empty (rd_ptr = wr_ptr = 0, fill = 0).
  - out_valid = 0, out_data = 0, underrun_cnt = 0, drop = 0.
  - Reset has priority over every other event in the same cycle. Mid-operation reset flushes all queued words; any in-flight pop is not completed.
  - lfsr_state is never reset by this block.
- Decimation counter:
  - Counts 0..DECIM-1 and wraps to 0.
  - A sample event occurs on every edge where the counter is DECIM-1.
  - The first sample is at the DECIM-th edge after rst is released.
- Sample event:
  - lfsr_state[WIDTH-1:0] is written to mem[wr_ptr] and wr_ptr advances.
  - The write is permitted when fill < DEPTH, or when fill == DEPTH and a pop occurs at the same edge.
  - Otherwise the sample is discarded, drop = 1 for the next cycle, and the decimation counter still wraps.
- Pop:
  - Occurs at an edge where out_valid & out_ready; rd_ptr advances.
  - out_ready while out_valid = 0 has no effect on the FIFO.
- Output data path:
  - out_valid = (fill != 0).
  - out_data = mem[rd_ptr] when valid, and 0 when empty.
  - There is no combinational path from lfsr_state to any output.
- Latency:
  - A word sampled at edge N is visible on out_data/out_valid after edge N (cycle N+1).
  - out_data must remain stable while out_valid = 1 and out_ready = 0.
- fill accounting:
  - fill increments on push-only and decrements on pop-only.
  - fill is unchanged on simultaneous push and pop, including at full and at fill = 1.
  - Pointers wrap modulo DEPTH.
- Empty with simultaneous push and pop: cannot occur, because pop requires out_valid.
- underrun_cnt:
  - Increments at every edge with out_ready = 1 and out_valid = 0.
  - Saturates at 2^CNT_W-1 and never wraps; cleared only by rst.
- Elaboration checks: an illegal parameter combination (DECIM < WIDTH, WIDTH > 128, DEPTH not a power of two) raises an elaboration-time error.

Decomposition:
- Shared package rng_pkg:
  - RNG_LFSR_W = 128.
  - Default WIDTH, DECIM and DEPTH constants.
  - typedef rng_word_t (logic [31:0]).
- One natural sub-module: fifo_sync, a generic FWFT synchronous FIFO (WIDTH, DEPTH; push/pop, full/empty/fill, sync active-high rst).
- rng_word_buffer contains the decimation counter, push gating, drop pulse and underrun counter.

Test Plan (defaults WIDTH=32, DECIM=32, DEPTH=4; bench drives lfsr_state = 128'(edge index k since reset release)):
- Fill from reset, out_ready=0:
  - Sample writes occur at k = 31, 63, 95, 127.
  - out_valid rises at cycle 32 with out_data = 32'd31; fill reaches 4 after k = 127.
  - At k = 159, drop pulses and fill stays 4.
- Drain: after fill = 4, out_ready=1 for 4 cycles -> out_data sequence 31, 63, 95, 127; out_valid then 0 and fill = 0.
- Simultaneous push and pop at full:
  - Hold fill = 4 and assert out_ready exactly on a sample edge.
  - Pop of the head and push of the new sample both occur; fill stays 4 and drop stays 0.
- Underrun:
  - out_ready=1 continuously from reset -> underrun_cnt = 31 at the first sample edge.
  - Each word is consumed in the cycle it appears.
  - With CNT_W=4, the counter saturates at 15.
- Reset mid-operation: fill = 3, assert rst for 1 cycle -> next cycle fill = 0, out_valid = 0, underrun_cnt = 0, and the next sample occurs 32 edges after release.
- Backpressure stability: out_valid=1, out_ready=0 held for 100 cycles -> out_data stays constant throughout.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared constants and types for the RNG word buffer slice.
package rng_pkg;

  localparam int unsigned RNG_LFSR_W    = 128;
  localparam int unsigned RNG_WIDTH_DEF = 32;
  localparam int unsigned RNG_DECIM_DEF = 32;
  localparam int unsigned RNG_DEPTH_DEF = 4;
  localparam int unsigned RNG_CNT_W_DEF = 16;

  typedef logic [31:0] rng_word_t;

endpackage

// File: rtl/fifo_sync.sv
// Generic first-word-fall-through synchronous FIFO with synchronous active-high reset.
module fifo_sync
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH = RNG_WIDTH_DEF,
  parameter int unsigned DEPTH = RNG_DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned FillW = PtrW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("fifo_sync: DEPTH must be a power of two and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             push_ok, pop_ok;

  // Qualify requests: pop needs data, push needs room or a same-edge pop.
  always_comb begin
    pop_ok   = pop_i && (fill_q != '0);
    push_ok  = push_i && ((fill_q != FillW'(DEPTH)) || pop_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    fill_d   = fill_q;
    unique case ({push_ok, pop_ok})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Head word falls through; forced to zero while empty.
  always_comb begin
    empty_o = (fill_q == '0);
    full_o  = (fill_q == FillW'(DEPTH));
    fill_o  = fill_q;
    data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/rng_word_buffer.sv
// Decimates the LFSR state into WIDTH-bit words, queues them and counts consumer starvation.
module rng_word_buffer
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH = RNG_WIDTH_DEF,
  parameter int unsigned DECIM = RNG_DECIM_DEF,
  parameter int unsigned DEPTH = RNG_DEPTH_DEF,
  parameter int unsigned CNT_W = RNG_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RNG_LFSR_W-1:0]  lfsr_state,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill,
  output logic [CNT_W-1:0]       underrun_cnt,
  output logic                   drop
);

  localparam int unsigned CntW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DECIM - 1);

  if (WIDTH < 1 || WIDTH > RNG_LFSR_W) begin : gen_width_check
    $error("rng_word_buffer: WIDTH must be in 1..128");
  end
  if (DECIM < WIDTH) begin : gen_decim_check
    $error("rng_word_buffer: DECIM must be >= WIDTH");
  end

  // Only the low WIDTH bits are ever sampled.
  if (WIDTH < RNG_LFSR_W) begin : gen_unused_lfsr
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr_state[RNG_LFSR_W-1:WIDTH];
  end

  logic [CntW-1:0]  dec_q, dec_d;
  logic [CNT_W-1:0] under_q, under_d;
  logic             drop_q, drop_d;
  logic             sample, pop, push;
  logic             fifo_full, fifo_empty;

  // Sample gating, drop detection and saturating starvation count.
  always_comb begin
    sample  = (dec_q == CntMax);
    dec_d   = sample ? '0 : dec_q + 1'b1;
    pop     = out_ready && out_valid;
    push    = sample && (!fifo_full || pop);
    drop_d  = sample && !push;
    under_d = under_q;
    if (out_ready && !out_valid && (under_q != '1)) begin
      under_d = under_q + 1'b1;
    end
  end

  // Decimation counter, drop pulse and underrun counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q   <= '0;
      under_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      under_q <= under_d;
      drop_q  <= drop_d;
    end
  end

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (lfsr_state[WIDTH-1:0]),
    .pop_i   (pop),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  // Registered status outputs.
  always_comb begin
    out_valid    = !fifo_empty;
    underrun_cnt = under_q;
    drop         = drop_q;
  end

endmodule
